// File: rtl/nt_pkg.sv
// Shared constants for the neurotransmitter filter: channel count, level width,
// channel indices and packed-bus width.
package nt_pkg;

   localparam int unsigned NUM_CH  = 5;
   localparam int unsigned LEVEL_W = 2;
   localparam int unsigned CNT_W   = 4;
   localparam int unsigned BUS_W   = NUM_CH * LEVEL_W;

   localparam int unsigned GABA       = 0;
   localparam int unsigned DOPAMINE   = 1;
   localparam int unsigned SEROTONIN  = 2;
   localparam int unsigned CORTISOL   = 3;
   localparam int unsigned ADRENALINE = 4;

endpackage

// File: rtl/nt_filter_channel.sv
// One debounced channel: publishes a new level once it has persisted HOLD_CYCLES edges.
// Optional NT_FILTER_STEP_LIMIT_EN: each publish moves the level a single step toward raw.
module nt_filter_channel
   import nt_pkg::*;
#(
   parameter int unsigned       HOLD_CYCLES = 4,
   parameter logic [LEVEL_W-1:0] RESET_VAL  = 2'd1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               freeze,
   input  logic [LEVEL_W-1:0] raw,
   output logic [LEVEL_W-1:0] pub,
   output logic               changed
);

   localparam logic [CNT_W-1:0] HOLD = CNT_W'(HOLD_CYCLES);

   logic [LEVEL_W-1:0] cand;
   logic [LEVEL_W-1:0] pub_next;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   n;

   // cnt stays below HOLD, so cnt+1 cannot wrap
   always_comb begin
      n = (raw == cand) ? cnt + CNT_W'(1) : CNT_W'(1);
`ifdef NT_FILTER_STEP_LIMIT_EN
      pub_next = (raw > pub) ? pub + LEVEL_W'(1) : pub - LEVEL_W'(1);
`else
      pub_next = raw;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pub     <= RESET_VAL;
         cand    <= RESET_VAL;
         cnt     <= '0;
         changed <= 1'b0;
      end else if (freeze) begin
         changed <= 1'b0;
      end else if (raw == pub) begin
         cand    <= raw;
         cnt     <= '0;
         changed <= 1'b0;
      end else if (n >= HOLD) begin
         pub     <= pub_next;
         cnt     <= '0;
         changed <= 1'b1;
      end else begin
         cand    <= raw;
         cnt     <= n;
         changed <= 1'b0;
      end
   end

endmodule

// File: rtl/neurotransmitter_filter.sv
// Five independent debounce channels packed onto one registered level bus.
// Optional NT_FILTER_STEP_LIMIT_EN selects single-step publishing in every channel.
module neurotransmitter_filter
   import nt_pkg::*;
#(
   parameter int unsigned     HOLD_CYCLES = 4,
   parameter logic [BUS_W-1:0] RESET_LEVEL = 10'h157
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [BUS_W-1:0]  raw_levels,
   input  logic              freeze,
   output logic [BUS_W-1:0]  neurotransmitter_level,
   output logic [NUM_CH-1:0] level_changed
);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      nt_filter_channel #(
         .HOLD_CYCLES (HOLD_CYCLES),
         .RESET_VAL   (RESET_LEVEL[LEVEL_W*i +: LEVEL_W])
      ) u_ch (
         .clk     (clk),
         .rst     (rst),
         .freeze  (freeze),
         .raw     (raw_levels[LEVEL_W*i +: LEVEL_W]),
         .pub     (neurotransmitter_level[LEVEL_W*i +: LEVEL_W]),
         .changed (level_changed[i])
      );
   end

endmodule

// File: tb/tb_neurotransmitter_filter.sv
// Testbench for neurotransmitter_filter: directed scenarios plus random stimulus
// against an integer reference model of the debounce rules.
module tb_neurotransmitter_filter;

   localparam int          HOLD    = 4;
   localparam logic [9:0]  RST_LVL = 10'h157;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] raw_levels = '0;
   logic       freeze = 1'b0;
   logic [9:0] neurotransmitter_level;
   logic [4:0] level_changed;

   int checks = 0;
   int errors = 0;

   int         m_pub [5];
   int         m_cand[5];
   int         m_run [5];
   logic [4:0] m_chg;

   neurotransmitter_filter #(
      .HOLD_CYCLES (HOLD),
      .RESET_LEVEL (RST_LVL)
   ) dut (
      .clk                    (clk),
      .rst                    (rst),
      .raw_levels             (raw_levels),
      .freeze                 (freeze),
      .neurotransmitter_level (neurotransmitter_level),
      .level_changed          (level_changed)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [9:0] model_bus();
      logic [9:0] b;
      for (int c = 0; c < 5; c++) b[2*c +: 2] = 2'(m_pub[c]);
      return b;
   endfunction

   // One clock edge of the reference: a value different from the published one
   // must be seen HOLD times in a row (freeze pauses, does not reset, the run).
   function automatic void model_edge(input logic [9:0] r, input logic f, input logic rs);
      for (int c = 0; c < 5; c++) begin
         int v;
         v = int'(r[2*c +: 2]);
         m_chg[c] = 1'b0;
         if (rs) begin
            m_pub[c]  = int'(RST_LVL[2*c +: 2]);
            m_cand[c] = m_pub[c];
            m_run[c]  = 0;
         end else if (!f) begin
            if (v == m_pub[c]) begin
               m_cand[c] = v;
               m_run[c]  = 0;
            end else begin
               int len;
               len = (v == m_cand[c]) ? m_run[c] + 1 : 1;
               if (len >= HOLD) begin
`ifdef NT_FILTER_STEP_LIMIT_EN
                  m_pub[c] = (v > m_pub[c]) ? m_pub[c] + 1 : m_pub[c] - 1;
`else
                  m_pub[c] = v;
`endif
                  m_run[c] = 0;
                  m_chg[c] = 1'b1;
               end else begin
                  m_cand[c] = v;
                  m_run[c]  = len;
               end
            end
         end
      end
   endfunction

   task automatic cyc(input logic [9:0] r, input logic f, input logic rs);
      raw_levels = r;
      freeze     = f;
      rst        = rs;
      @(posedge clk);
      model_edge(r, f, rs);
      #1;
      check("level", 32'(neurotransmitter_level), 32'(model_bus()));
      check("strobe", 32'(level_changed), 32'(m_chg));
   endtask

   initial begin
      logic [9:0] r;
      int ch;

      // reset with raw=0, then first change only after HOLD edges
      cyc(10'h000, 1'b0, 1'b1);
      check("rst_level", 32'(neurotransmitter_level), 32'h157);
      check("rst_strobe", 32'(level_changed), 32'h0);
      repeat (3) cyc(10'h000, 1'b0, 1'b0);
      check("rst_hold3", 32'(neurotransmitter_level), 32'h157);
      cyc(10'h000, 1'b0, 1'b0);
      check("rst_first_change_strobe", 32'(level_changed), 32'h1f);

      // GABA 3->1 debounce
      cyc(10'h157, 1'b0, 1'b1);
      repeat (3) cyc(10'h155, 1'b0, 1'b0);
      cyc(10'h155, 1'b0, 1'b0);
`ifdef NT_FILTER_STEP_LIMIT_EN
      check("gaba_pub", 32'(neurotransmitter_level[1:0]), 32'd2);
`else
      check("gaba_pub", 32'(neurotransmitter_level[1:0]), 32'd1);
`endif
      check("gaba_strobe", 32'(level_changed), 32'h01);
      cyc(10'h155, 1'b0, 1'b0);
      check("gaba_strobe_once", 32'(level_changed), 32'h00);

      // dopamine glitch rejection
      cyc(10'h157, 1'b0, 1'b1);
      repeat (2) cyc(10'h15b, 1'b0, 1'b0);
      repeat (5) cyc(10'h157, 1'b0, 1'b0);
      check("dopa_glitch", 32'(neurotransmitter_level), 32'h157);

      // cortisol restart: 2 for two cycles, then 3
      repeat (2) cyc(10'h197, 1'b0, 1'b0);
      repeat (3) cyc(10'h1d7, 1'b0, 1'b0);
      check("cort_not_yet", 32'(neurotransmitter_level[7:6]), 32'd1);
      cyc(10'h1d7, 1'b0, 1'b0);
      check("cort_strobe", 32'(level_changed), 32'h08);

      // freeze with all channels changing, then simultaneous publish
      cyc(10'h157, 1'b0, 1'b1);
      repeat (6) cyc(10'h2aa, 1'b1, 1'b0);
      check("frz_level", 32'(neurotransmitter_level), 32'h157);
      repeat (3) cyc(10'h2aa, 1'b0, 1'b0);
      cyc(10'h2aa, 1'b0, 1'b0);
      check("frz_all_strobe", 32'(level_changed), 32'h1f);
      check("frz_all_level", 32'(neurotransmitter_level), 32'h2aa);

      // adrenaline 1->3 held
      cyc(10'h157, 1'b0, 1'b1);
      repeat (8) cyc(10'h357, 1'b0, 1'b0);
      check("adr_final", 32'(neurotransmitter_level[9:8]), 32'd3);

      // random mix: sticky values, occasional freeze and reset
      r = RST_LVL;
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(3) == 0) begin
            ch = int'($urandom_range(4));
            r[2*ch +: 2] = 2'($urandom_range(3));
         end
         cyc(r, ($urandom_range(15) == 0), ($urandom_range(63) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/neurotransmitter_filter.md
NEUROTRANSMITTER_FILTER -- requirements
Module: neurotransmitter_filter

Interface
REQ-001 Parameter HOLD_CYCLES, default 4, range 1..15: consecutive cycles a new channel value must persist before it is published.
REQ-002 Parameter RESET_LEVEL, default 10'h157: published bus value after reset (GABA=3, all other channels=1).
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 raw_levels  input  10  unfiltered 2-bit channel levels: [1:0] GABA, [3:2] dopamine, [5:4] serotonin, [7:6] cortisol, [9:8] adrenaline.
REQ-006 freeze  input  1  when high, no channel publishes and all hold counters keep their value.
REQ-007 neurotransmitter_level  output  10  registered filtered levels, same channel packing as raw_levels.
REQ-008 level_changed  output  5  registered one-cycle strobe, bit i set on the cycle after channel i's published value changed.

Function
REQ-009 The block SHALL hold per-channel state: published value pub (2 bit), candidate value cand (2 bit), hold counter cnt (4 bit).
REQ-010 Each edge with freeze low and raw==pub, a channel SHALL set cand<=raw and cnt<=0, keeping pub unchanged.
REQ-011 Each edge with freeze low and raw!=pub, a channel SHALL compute n = cnt+1 if raw==cand, else n = 1.
REQ-012 If n >= HOLD_CYCLES, the channel SHALL publish (REQ-015), set cnt<=0, and set level_changed[i]<=1.
REQ-013 If n < HOLD_CYCLES, the channel SHALL set cand<=raw and cnt<=n, keeping pub unchanged.
REQ-014 With HOLD_CYCLES=4, a change held stable from edge k SHALL appear on neurotransmitter_level after edge k+3; any intervening different value restarts the count at 1.
REQ-015 Publish SHALL set pub<=raw; behaviour under NT_FILTER_STEP_LIMIT_EN is given in Configuration.
REQ-016 level_changed[i] SHALL be 0 on every edge where channel i does not publish, so it never stays high for two cycles from a single change.
REQ-017 With freeze high, pub, cand and cnt SHALL hold and level_changed SHALL be 0.
REQ-018 Channels SHALL be fully independent; simultaneous publishes on several channels SHALL set several level_changed bits on the same edge.
REQ-019 cnt SHALL never exceed HOLD_CYCLES-1, so no wrap-around occurs.
REQ-020 neurotransmitter_level SHALL equal the concatenated pub registers with no combinational path from raw_levels.

Reset
REQ-021 On a clock edge with rst high, the block SHALL set pub<=RESET_LEVEL, cand<=RESET_LEVEL, cnt<=0 and level_changed<=0, overriding freeze and any pending count.
REQ-022 The first publish after reset SHALL need a full HOLD_CYCLES of stable input; partial counts accumulated before reset are discarded.

Configuration
REQ-023 Macro NT_FILTER_STEP_LIMIT_EN SHALL select the publish behaviour.
REQ-024 With NT_FILTER_STEP_LIMIT_EN defined, a publish SHALL move pub one step toward raw (pub±1) and set cnt<=0, so a 0->3 change needs three successive hold periods.
REQ-025 With NT_FILTER_STEP_LIMIT_EN undefined, a publish SHALL set pub<=raw directly.

Structure
REQ-026 Shared package nt_pkg SHALL hold the channel count (5), the level width (2), the channel index constants (GABA=0, DOPAMINE=1, SEROTONIN=2, CORTISOL=3, ADRENALINE=4) and the packed-bus width (10).
REQ-027 The per-channel logic SHALL be a sub-module nt_filter_channel (pub, cand and cnt registers plus publish logic), instantiated 5 times via generate.

Verification
REQ-028 Reset check: drive rst for 1 cycle with raw_levels=10'h000, then release -> neurotransmitter_level=10'h157 and level_changed=0; the first change appears 4 edges later.
REQ-029 Debounce: raw GABA 3->1 held 4 cycles -> output [1:0]=1 after the 4th edge, with level_changed=5'b00001 for exactly one cycle.
REQ-030 Glitch rejection: dopamine raw toggles 1->2 for 2 cycles then back to 1 -> no output change and no strobe.
REQ-031 Restart: cortisol raw 1->2 for 2 cycles, then 3 for 4 cycles -> publishes 3 (or 2 with step limit) only after the 4th cycle of value 3.
REQ-032 Freeze and simultaneity: freeze high for 6 cycles while all channels change -> nothing publishes; after release, all channels publish on the same edge -> level_changed=5'b11111.
REQ-033 Step limit (macro on): adrenaline raw 1->3 held -> output becomes 2 after 4 edges and 3 after 8 edges, with two separate strobes.
